add_approx_pipe: RTL and testbench

ADD_APPROX_PIPE -- requirements
Module: add_approx_pipe

---
 rtl/add_approx_pipe.sv | 131 +++++++++++++
 tb/tb_add_approx_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/add_approx_pipe.sv
// Two-stage approximate adder (exact / lower-OR / ones-fill / truncate) with
// valid-ready handshakes and running error statistics on delivered beats.
module add_approx_pipe #(
  parameter int W  = 8,
  parameter int KW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [1:0]    mode,
  input  logic [KW-1:0] k,
  input  logic          clr_stats,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    o,
  output logic [W+1:0]  err,
  output logic [W:0]    max_err,
  output logic [15:0]   err_cnt
);

  logic          s1_valid_q, s1_valid_d;
  logic [W:0]    s1_exact_q, s1_exact_d;
  logic [W:0]    s1_approx_q, s1_approx_d;
  logic          out_valid_q, out_valid_d;
  logic [W:0]    o_q, o_d;
  logic [W+1:0]  err_q, err_d;
  logic [W:0]    max_err_q, max_err_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic [31:0]   k_ext, ke;
  logic [W-1:0]  lo_mask, top_mask, hi_a, hi_b;
  logic          cin;
  logic [W:0]    exact_sum, upper_sum, carry_w, approx_sum;
  logic [W:0]    abs_err;
  logic          s2_en, s1_en, out_xfer;

  // Approximation datapath, evaluated on the incoming operands.
  always_comb begin
    k_ext     = 32'(k);
    ke        = (k_ext > 32'(W)) ? 32'(W) : k_ext;
    lo_mask   = ~({W{1'b1}} << ke);
    top_mask  = lo_mask & ~(lo_mask >> 1);
    hi_a      = a & ~lo_mask;
    hi_b      = b & ~lo_mask;
    cin       = |(a & b & top_mask);
    exact_sum = {1'b0, a} + {1'b0, b};
    upper_sum = {1'b0, hi_a} + {1'b0, hi_b};
    // Carry into bit Ke has weight lo_mask + 1.
    carry_w   = cin ? ({1'b0, lo_mask} + 1'b1) : '0;
    case (mode)
      2'd1:    approx_sum = (upper_sum + carry_w) | {1'b0, (a | b) & lo_mask};
      2'd2:    approx_sum = upper_sum | {1'b0, lo_mask};
      2'd3:    approx_sum = upper_sum;
      default: approx_sum = exact_sum;
    endcase
  end

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_exact_d  = s1_exact_q;
    s1_approx_d = s1_approx_q;
    out_valid_d = out_valid_q;
    o_d         = o_q;
    err_d       = err_q;
    max_err_d   = max_err_q;
    err_cnt_d   = err_cnt_q;
    abs_err     = (W + 1)'(err_q[W+1] ? -err_q : err_q);

    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_exact_d  = exact_sum;
        s1_approx_d = approx_sum;
      end
    end

    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_d   = s1_approx_q;
        err_d = {1'b0, s1_exact_q} - {1'b0, s1_approx_q};
      end
    end

    // A clear takes priority over accounting the beat transferring this edge.
    if (clr_stats) begin
      max_err_d = '0;
      err_cnt_d = '0;
    end else if (out_xfer) begin
      if (abs_err > max_err_q) max_err_d = abs_err;
      if (err_q != '0 && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      out_valid_q <= 1'b0;
      o_q         <= '0;
      err_q       <= '0;
      max_err_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_exact_q  <= s1_exact_d;
      s1_approx_q <= s1_approx_d;
      out_valid_q <= out_valid_d;
      o_q         <= o_d;
      err_q       <= err_d;
      max_err_q   <= max_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign o         = o_q;
  assign err       = err_q;
  assign max_err   = max_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_add_approx_pipe.sv
// Directed bench for add_approx_pipe: hand-computed vectors, backpressure,
// statistics clear/saturation and reset with beats in flight.
module tb_add_approx_pipe;
  localparam int W  = 8;
  localparam int KW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic [1:0]    mode;
  logic [KW-1:0] k;
  logic          clr_stats;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    o;
  logic [W+1:0]  err;
  logic [W:0]    max_err;
  logic [15:0]   err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_max = 0;
  int exp_cnt = 0;

  add_approx_pipe #(.W(W), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .k(k), .clr_stats(clr_stats),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .err(err),
    .max_err(max_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic accept_beat(input logic [1:0] m, input logic [3:0] kk,
                             input logic [7:0] aa, input logic [7:0] bb);
    mode = m; k = kk; a = aa; b = bb; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  // One isolated beat: accept, confirm 2-cycle latency, check result and stats.
  task automatic vec(input string tag, input logic [1:0] m, input logic [3:0] kk,
                     input logic [7:0] aa, input logic [7:0] bb,
                     input logic [8:0] eo, input logic [9:0] ee);
    int ab;
    out_ready = 1'b1;
    accept_beat(m, kk, aa, bb);
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_o"}, 32'(o), 32'(eo));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    tick;
    ab = ee[9] ? (1024 - int'(ee)) : int'(ee);
    if (ee != 10'd0) exp_cnt++;
    if (ab > exp_max) exp_max = ab;
    chk({tag, "_maxerr"}, 32'(max_err), 32'(exp_max));
    chk({tag, "_errcnt"}, 32'(err_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = '0; k = '0;
    clr_stats = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_max", 32'(max_err), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick; tick;
    rst_n = 1'b1;
    tick;

    vec("m0_ff_01",   2'd0, 4'd0,  8'hFF, 8'h01, 9'h100, 10'h000);
    vec("m1_k4",      2'd1, 4'd4,  8'h0F, 8'h01, 9'h00F, 10'h001);
    vec("m2_k3",      2'd2, 4'd3,  8'h05, 8'h03, 9'h007, 10'h001);
    vec("m3_k2",      2'd3, 4'd2,  8'hFF, 8'hFF, 9'h1F8, 10'h006);
    vec("m3_k15",     2'd3, 4'd15, 8'h12, 8'h34, 9'h000, 10'h046);
    vec("m2_neg",     2'd2, 4'd4,  8'h10, 8'h00, 9'h01F, 10'h3F1);
    vec("m1_carry",   2'd1, 4'd4,  8'h18, 8'h08, 9'h028, 10'h3F8);
    vec("m3_k0",      2'd3, 4'd0,  8'h37, 8'h49, 9'h080, 10'h000);

    // Backpressure: three beats offered back to back while the sink stalls.
    out_ready = 1'b0;
    mode = 2'd0; k = 4'd0; a = 8'h01; b = 8'h02; in_valid = 1'b1;
    tick;
    a = 8'h10; b = 8'h20;
    chk("bp_ready_b1", 32'(in_ready), 32'd1);
    tick;
    a = 8'h80; b = 8'h80;
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_o0", 32'(o), 32'h003);
    tick;
    chk("bp_hold_o", 32'(o), 32'h003);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    tick;
    chk("bp_hold_o2", 32'(o), 32'h003);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    chk("bp_o1", 32'(o), 32'h030);
    tick;
    chk("bp_o2", 32'(o), 32'h100);
    chk("bp_valid2", 32'(out_valid), 32'd1);
    tick;
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Clear coincident with a +6 error transfer: the clear wins.
    accept_beat(2'd3, 4'd2, 8'hFF, 8'hFF);
    tick;
    chk("clr_err_pre", 32'(err), 32'h006);
    clr_stats = 1'b1;
    tick;
    clr_stats = 1'b0;
    chk("clr_max", 32'(max_err), 32'd0);
    chk("clr_cnt", 32'(err_cnt), 32'd0);
    chk("clr_pipe", 32'(out_valid), 32'd0);

    // Saturation: 65537 streamed nonzero-error beats.
    mode = 2'd3; k = 4'd2; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) tick;
    in_valid = 1'b0;
    tick; tick;
    chk("sat_cnt", 32'(err_cnt), 32'hFFFF);
    chk("sat_max", 32'(max_err), 32'd6);
    chk("sat_drained", 32'(out_valid), 32'd0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    accept_beat(2'd0, 4'd0, 8'h01, 8'h01);
    accept_beat(2'd0, 4'd0, 8'h02, 8'h02);
    chk("inflight_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_o", 32'(o), 32'd0);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_max", 32'(max_err), 32'd0);
    chk("rst2_cnt", 32'(err_cnt), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    tick;
    rst_n = 1'b1;
    exp_max = 0;
    exp_cnt = 0;
    vec("post_rst", 2'd1, 4'd4, 8'h0F, 8'h01, 9'h00F, 10'h001);
    tick;
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
